// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address field helpers for the direct-mapped cache.
package cache_pkg;

  localparam int ADDR_W         = 15;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MEM_WAIT,
    REFILL
  } state_t;

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  // Tag and index together: the line number within main memory.
  function automatic logic [ADDR_W-OFFSET_W-1:0] addr_line(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_W];
  endfunction

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFFSET_W-1:0] off);
    return line[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Valid bits and tag array for the direct-mapped cache: combinational lookup, single write port.
module cache_tag_store #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               lookup_hit,
  input  logic               write_en,
  input  logic [INDEX_W-1:0] write_index,
  input  logic [TAG_W-1:0]   write_tag
);

  localparam int NUM_LINES = 2 ** INDEX_W;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_mem [NUM_LINES];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (write_en) begin
      valid[write_index] <= 1'b1;
    end
  end

  // NOTE: array storage is not reset; the valid bits alone decide whether its contents are used.
  always_ff @(posedge clk) begin
    if (write_en) begin
      tag_mem[write_index] <= write_tag;
    end
  end

  assign lookup_hit = valid[lookup_index] && (tag_mem[lookup_index] == lookup_tag);

endmodule

// File: rtl/dm_cache_controller.sv
// Direct-mapped read-only cache controller: lookup, line fetch from main memory, refill, respond.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module dm_cache_controller
  import cache_pkg::*;
#(
  parameter int INDEX_W     = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cache_flush,
  output logic              cpu_resp_valid,
  output logic [WORD_W-1:0] cpu_data_out,
  output logic              cpu_hit,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_line_in
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NUM_LINES = 2 ** INDEX_W;
  localparam int CNT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_d, resp_valid_d, hit_d, mre_d;
  logic [WORD_W-1:0]   data_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                flush_take, refill_we, lookup_hit;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] off;
  logic [LINE_W-1:0]   data_mem [NUM_LINES];

  assign idx = addr_q[OFFSET_W +: INDEX_W];
  assign tag = addr_q[ADDR_W-1 -: TAG_W];
  assign off = addr_offset(addr_q);

  cache_tag_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tag_store (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush_take),
    .lookup_index (idx),
    .lookup_tag   (tag),
    .lookup_hit   (lookup_hit),
    .write_en     (refill_we),
    .write_index  (idx),
    .write_tag    (tag)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    resp_valid_d  = 1'b0;
    data_d        = cpu_data_out;
    hit_d         = cpu_hit;
    mre_d         = mem_read_enable;
    mem_addr_d    = mem_address;
    flush_take    = 1'b0;
    refill_we     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cache_flush) begin
          flush_take = 1'b1;
        end else if (cpu_req_valid && cpu_req_ready) begin
          addr_d  = cpu_address;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lookup_hit) begin
          resp_valid_d = 1'b1;
          data_d       = line_word(data_mem[idx], off);
          hit_d        = 1'b1;
          state_d      = IDLE;
        end else begin
          mem_addr_d = {addr_line(addr_q), {OFFSET_W{1'b0}}};
          mre_d      = 1'b1;
          cnt_d      = '0;
          state_d    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          mre_d   = 1'b0;
          state_d = REFILL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REFILL: begin
        refill_we    = 1'b1;
        resp_valid_d = 1'b1;
        data_d       = line_word(mem_line_in, off);
        hit_d        = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A flush cycle blocks acceptance for one cycle so the coincident request is dropped.
    ready_d = (state_d == IDLE) && !flush_take;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      addr_q          <= '0;
      cnt_q           <= '0;
      cpu_req_ready   <= 1'b1;
      cpu_resp_valid  <= 1'b0;
      cpu_data_out    <= '0;
      cpu_hit         <= 1'b0;
      mem_read_enable <= 1'b0;
      mem_address     <= '0;
    end else begin
      state           <= state_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      cpu_req_ready   <= ready_d;
      cpu_resp_valid  <= resp_valid_d;
      cpu_data_out    <= data_d;
      cpu_hit         <= hit_d;
      mem_read_enable <= mre_d;
      mem_address     <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (refill_we) begin
      data_mem[idx] <= mem_line_in;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush_take) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_valid_d) begin
      if (hit_d && (hit_count != '1)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (!hit_d && (miss_count != '1)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
